// File: rtl/vx_gbar_ctrl_pkg.sv
// Shared types and width helpers for the global-barrier controller.
package vx_gbar_ctrl_pkg;

    // Width of an index into n items; never narrower than one bit.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GBAR_NUM_REQS      = 4;
    localparam int GBAR_NUM_BARRIERS  = 8;
    localparam int GBAR_NB_WIDTH      = log2up(GBAR_NUM_BARRIERS);
    localparam int GBAR_NC_WIDTH      = log2up(GBAR_NUM_REQS);
    localparam int GBAR_PERF_CTR_BITS = 32;

    // Per-core barrier request payload at the default configuration.
    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
        logic [GBAR_NC_WIDTH-1:0] size_m1;
    } gbar_req_t;

    // Release broadcast payload at the default configuration.
    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
    } gbar_rsp_t;

endpackage

// File: rtl/vx_gbar_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the pointer moves past the
// granted requester only when the grant is consumed (unlock).
module vx_gbar_ctrl_rr_arbiter #(
    parameter int NUM_REQS  = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQS-1:0]  requests,
    input  logic                 unlock,
    output logic [NUM_REQS-1:0]  grant_onehot,
    output logic [IDX_WIDTH-1:0] grant_index,
    output logic                 grant_valid
);

    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH-1:0] scan_idx;
    int                   scan_int;

    // Pick the first active requester at or after the pointer, wrapping around.
    always_comb begin
        grant_onehot = '0;
        grant_index  = '0;
        grant_valid  = 1'b0;
        scan_int     = 0;
        scan_idx     = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            scan_int = int'(ptr_q) + i;
            if (scan_int >= NUM_REQS) begin
                scan_int = scan_int - NUM_REQS;
            end
            scan_idx = IDX_WIDTH'(scan_int);
            if (!grant_valid && requests[scan_idx]) begin
                grant_valid            = 1'b1;
                grant_index            = scan_idx;
                grant_onehot[scan_idx] = 1'b1;
            end
        end
    end

    // Advance the pointer to one past the winner on an accepted grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (unlock && grant_valid) begin
            if (int'(grant_index) == NUM_REQS - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_index + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_gbar_ctrl.sv
// Cluster global-barrier controller: arbitrates core barrier requests, tracks
// per-barrier arrival masks and broadcasts a one-cycle release pulse.
// Optional macro GBAR_PERF_EN adds release and wait-cycle counters.
module vx_gbar_ctrl
    import vx_gbar_ctrl_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int NB_WIDTH     = log2up(NUM_BARRIERS),
    parameter int NC_WIDTH     = log2up(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid,
    input  logic [NUM_REQS*NB_WIDTH-1:0] req_id,
    input  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1,
    output logic [NUM_REQS-1:0]          req_ready,
    output logic                         rsp_valid,
    output logic [NB_WIDTH-1:0]          rsp_id,
`ifdef GBAR_PERF_EN
    output logic [GBAR_PERF_CTR_BITS-1:0] perf_releases,
    output logic [GBAR_PERF_CTR_BITS-1:0] perf_wait_cycles,
`endif
    output logic                         err
);

    logic [NUM_REQS-1:0] arrive_mask_q [NUM_BARRIERS];
    logic [NC_WIDTH-1:0] size_q        [NUM_BARRIERS];

    logic [NUM_REQS-1:0] grant_onehot;
    logic [NC_WIDTH-1:0] grant_index;
    logic                fire;

    logic [NB_WIDTH-1:0] sel_id;
    logic [NC_WIDTH-1:0] sel_size;
    logic [NUM_REQS-1:0] cur_mask;
    logic [NUM_REQS-1:0] new_mask;
    logic [NC_WIDTH-1:0] cur_size;
    logic                first_arrival;
    logic                dup_arrival;
    logic                size_mismatch;
    logic                complete;
    int                  arrive_cnt;
    int                  expected_cnt;

    vx_gbar_ctrl_rr_arbiter #(
        .NUM_REQS  (NUM_REQS),
        .IDX_WIDTH (NC_WIDTH)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (req_valid),
        .unlock       (1'b1),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index),
        .grant_valid  (fire)
    );

    // The grant is also the ready: an offered grant is always taken.
    assign req_ready = grant_onehot;

    // Decode the winning request and evaluate completion including this arrival.
    always_comb begin
        sel_id   = '0;
        sel_size = '0;
        for (int c = 0; c < NUM_REQS; c++) begin
            if (NC_WIDTH'(c) == grant_index) begin
                sel_id   = req_id[c*NB_WIDTH +: NB_WIDTH];
                sel_size = req_size_m1[c*NC_WIDTH +: NC_WIDTH];
            end
        end
        cur_mask = '0;
        cur_size = '0;
        if (int'(sel_id) < NUM_BARRIERS) begin
            cur_mask = arrive_mask_q[sel_id];
            cur_size = size_q[sel_id];
        end
        new_mask      = cur_mask | grant_onehot;
        first_arrival = (cur_mask == '0);
        dup_arrival   = cur_mask[grant_index];
        size_mismatch = !first_arrival && (sel_size != cur_size);
        arrive_cnt    = $countones(new_mask);
        expected_cnt  = (first_arrival ? int'(sel_size) : int'(cur_size)) + 1;
        // A repeated arrival never completes: the mask is left as it was.
        complete      = fire && !dup_arrival && (arrive_cnt == expected_cnt);
    end

    // Arrival-mask and latched-size storage per barrier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                arrive_mask_q[b] <= '0;
                size_q[b]        <= '0;
            end
        end else if (fire && (int'(sel_id) < NUM_BARRIERS)) begin
            if (complete) begin
                arrive_mask_q[sel_id] <= '0;
            end else if (!dup_arrival) begin
                arrive_mask_q[sel_id] <= new_mask;
            end
            if (first_arrival) begin
                size_q[sel_id] <= sel_size;
            end
        end
    end

    // Registered release pulse and sticky protocol-error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= complete;
            if (complete) begin
                rsp_id <= sel_id;
            end
            if (fire && (dup_arrival || size_mismatch)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef GBAR_PERF_EN
    logic any_pending;

    // Any barrier holding a partial arrival set counts as a wait cycle.
    always_comb begin
        any_pending = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            any_pending = any_pending | (|arrive_mask_q[b]);
        end
    end

    // Release and wait-cycle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_releases    <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (complete) begin
                perf_releases <= perf_releases + 1'b1;
            end
            if (any_pending) begin
                perf_wait_cycles <= perf_wait_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/vx_gbar_ctrl.md
# vx_gbar_ctrl

Cluster-level global-barrier controller; it owns the barrier bus that each core's warp scheduler drives when a warp executes a global barrier. Up to NUM_REQS cores raise barrier requests. The block arbitrates them round-robin, one per cycle, and tracks a per-barrier arrival mask of cores. When the last expected core arrives, it broadcasts a one-cycle release response to all cores.

## Interface
Parameters:
- NUM_REQS, 4: number of requesting cores; must be ≥ 2.
- NUM_BARRIERS, 8: number of global barrier IDs.
- NB_WIDTH, `LOG2UP(NUM_BARRIERS)`: barrier ID width.
- NC_WIDTH, `LOG2UP(NUM_REQS)`: core index / size_m1 width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: **asynchronous, active-high** reset.
- req_valid, input, NUM_REQS: per-core request valid.
- req_id, input, NUM_REQS×NB_WIDTH: barrier ID per core.
- req_size_m1, input, NUM_REQS×NC_WIDTH: participating cores minus 1.
- req_ready, output, NUM_REQS: grant; a request is accepted on valid&ready.
- rsp_valid, output, 1: release pulse, broadcast to all cores.
- rsp_id, output, NB_WIDTH: released barrier ID.
- err, output, 1: sticky protocol-error flag.

## Operation
- Arbitration:
  - One request accepted per cycle, round-robin over the cores with req_valid set.
  - The pointer advances to (granted index + 1) mod NUM_REQS only on acceptance.
  - req_ready is one-hot, or zero when no request is valid.
- The accepting core's identity is its port index; no core_id is carried on the bus.
- State per barrier b:
  - arrive_mask[b] (NUM_REQS bits).
  - size_q[b]: latched from the first arrival, i.e. when arrive_mask[b] is 0.
- On acceptance of core c for barrier b:
  - Compute cnt = popcount(arrive_mask[b] | onehot(c)).
  - The expected size is req_size_m1 on a first arrival, otherwise size_q[b].
  - If cnt == expected + 1: clear arrive_mask[b] and register rsp_valid=1 with rsp_id=b.
  - Otherwise: set bit c in arrive_mask[b].
- Error cases; each sets err and leaves it set until reset:
  - Core c already present in arrive_mask[b]: the request is accepted, the mask is unchanged, and no release is issued.
  - Later arrival with req_size_m1 ≠ size_q[b]: the latched size is kept and processing continues.
- rsp_valid is a single-cycle pulse. Barriers are independent, so several barriers may be partially filled at once.
- Reset values:
  - rsp_valid=0, rsp_id=0, err=0.
  - All arrive_mask and size_q cleared; RR pointer=0.
  - req_ready follows combinationally from req_valid, so it is 0 while all req_valid are 0.

## Timing
- Acceptance to release: 1 cycle. rsp_valid is high in the cycle after the completing request's valid&ready.
- Completion is evaluated on the accepting cycle, including the current arrival. A barrier of size 1 (size_m1=0) therefore releases one cycle after its single request.
- Back-to-back reuse of the same ID is legal: a request accepted in the release-pulse cycle starts a fresh episode.
- Two completions in consecutive cycles produce two consecutive pulses with their respective IDs.
- A requester holds valid/id/size stable until ready. Losers wait at most NUM_REQS−1 cycles.
- Reset asserted mid-episode discards all partial masks; rsp_valid drops asynchronously.

## Configuration
- `GBAR_PERF_EN` defined:
  - Adds output perf_releases (`PERF_CTR_BITS`): count of release pulses.
  - Adds output perf_wait_cycles (`PERF_CTR_BITS`): incremented every cycle where any arrive_mask is nonzero.
  - Both counters reset to 0.
- `GBAR_PERF_EN` undefined: neither port nor either counter exists.

## Structure
- Shared package (VX_gpu_pkg):
  - gbar_req_t struct {id, size_m1}.
  - gbar_rsp_t struct {id}.
  - NB_WIDTH/NC_WIDTH derivation.
- Sub-module: the existing round-robin arbiter VX_rr_arbiter (NUM_REQS, one-hot grant + index, unlock on fire).
- Mask/size storage and completion logic are local.

## Test plan
- Size 4, cores 0–3 each request ID 2 on separate cycles -> no pulse after the first three; rsp_valid=1, rsp_id=2 exactly one cycle after core 3 is accepted; mask[2]=0.
- All 4 cores assert ID 5 (size_m1=3) in the same cycle -> grants go 0,1,2,3 on consecutive cycles; a single pulse with rsp_id=5 on cycle 4.
- Interleaved IDs 1 and 6, size_m1=1: cores 0,1 on ID 1 and cores 2,3 on ID 6 -> two pulses in consecutive cycles, IDs 1 then 6.
- Core 1 requests ID 0 twice with size_m1=2 -> err=1 after the second acceptance; a later arrival by core 2 does not release; core 3 then completes the release.
- Size-mismatch request (3 vs latched 1) -> err=1; release still occurs using size 1.
- Reset pulsed while mask[3]=0b0011 -> all masks cleared, no pulse; four fresh arrivals are then needed to release.
